// File: rtl/sol32_bus_pkg.sv
// Shared types and helpers for the sol32 core-to-memory bus.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sol32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_RSVD = 2'b11
    } width_t;

    // True when an access of the given size cannot legally start at addr[1:0].
    // The reserved size is always treated as a fault.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (width_t'(width))
            W_BYTE:  bad = 1'b0;
            W_HALF:  bad = addr[0];
            W_WORD:  bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sol32_rr_arbiter.sv
// Two-requester (fetch/data) arbiter: round-robin when FAIR=1, data-first when FAIR=0.
// Latency: grant is combinational from the requests; history updates on the accept edge.
// Backpressure: grant is only consumed when the FSM pulses accept; otherwise history holds.
//
// Ports: Clock/Reset, fetch_req/data_req in, accept in (grant taken this cycle),
//        grant_vld out (some request pending), grant_data out (1 = data wins, 0 = fetch wins).
module sol32_rr_arbiter #(
    parameter int FAIR = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic fetch_req,
    input  logic data_req,
    input  logic accept,
    output logic grant_vld,
    output logic grant_data
);

    // Remembers who won last; resets to "data" so fetch takes the first tie.
    logic last_data;

    assign grant_vld  = fetch_req | data_req;
    assign grant_data = data_req & (~fetch_req | (FAIR == 0) | ~last_data);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_data <= 1'b1;
        end else if (accept) begin
            last_data <= grant_data;
        end
    end

endmodule

// File: rtl/sol32_mem_arbiter.sv
// Shares one variable-latency memory port between sol32 instruction fetch and load/store.
// Latency: IDLE (request seen) -> ACCESS -> RESP; a zero-wait memory gives Valid in the third cycle.
// Backpressure: core is held via combinational Stall; memory wait extends ACCESS up to TIMEOUT cycles.
//
// Ports: Clock, Reset (async active-low);
//        fetch side  FetchReq/FetchAddr in, FetchValid/FetchData out;
//        data side   DataRead/DataWrite/DataWidth/DataAddr/DataWrData in, DataValid/DataRdData out;
//        memory side MemReq/MemWrite/MemWidth/MemAddr/MemWrData out, MemReady/MemRdData in;
//        BusError (timeout or alignment fault strobe), Stall (core hold).
module sol32_mem_arbiter
    import sol32_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int FAIR    = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        FetchReq,
    input  logic [31:0] FetchAddr,
    output logic        FetchValid,
    output logic [31:0] FetchData,
    input  logic        DataRead,
    input  logic        DataWrite,
    input  logic [1:0]  DataWidth,
    input  logic [31:0] DataAddr,
    input  logic [31:0] DataWrData,
    output logic        DataValid,
    output logic [31:0] DataRdData,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [1:0]  MemWidth,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    input  logic        MemReady,
    input  logic [31:0] MemRdData,
    output logic        BusError,
    output logic        Stall
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        data_req;
    logic        grant_vld;
    logic        grant_data;
    logic [1:0]  sel_width;
    logic [31:0] sel_addr;
    logic        fault;
    logic        accept;
    logic        timed_out;
    logic        access_done;
    logic [15:0] tmo_cnt;
    logic        cur_data;

    // A simultaneous read+write is treated as a write, so the write bit alone
    // decides the direction once data is granted.
    assign data_req = DataRead | DataWrite;

    sol32_rr_arbiter #(
        .FAIR (FAIR)
    ) u_arb (
        .Clock      (Clock),
        .Reset      (Reset),
        .fetch_req  (FetchReq),
        .data_req   (data_req),
        .accept     (accept),
        .grant_vld  (grant_vld),
        .grant_data (grant_data)
    );

    assign sel_width = grant_data ? DataWidth : W_WORD;
    assign sel_addr  = grant_data ? DataAddr  : FetchAddr;
    assign fault     = is_misaligned(sel_width, sel_addr[1:0]);

    // Faulting grants never touch memory and do not move round-robin history.
    assign accept = (state == IDLE) && grant_vld && !fault;

    // MemReady on the last allowed cycle beats the timeout.
    assign timed_out   = (tmo_cnt == TMO_LAST) && !MemReady;
    assign access_done = MemReady || timed_out;

    assign Stall = (FetchReq & ~FetchValid) | (data_req & ~DataValid);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (access_done) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result strobes. Strobes default low so each is a single
    // cycle wide, landing in RESP.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            MemReq     <= 1'b0;
            MemWrite   <= 1'b0;
            MemWidth   <= 2'b00;
            MemAddr    <= '0;
            MemWrData  <= '0;
            FetchValid <= 1'b0;
            FetchData  <= '0;
            DataValid  <= 1'b0;
            DataRdData <= '0;
            BusError   <= 1'b0;
            tmo_cnt    <= '0;
            cur_data   <= 1'b0;
        end else begin
            FetchValid <= 1'b0;
            DataValid  <= 1'b0;
            BusError   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur_data <= grant_data;
                        if (fault) begin
                            BusError <= 1'b1;
                            if (grant_data) begin
                                DataValid  <= 1'b1;
                                DataRdData <= '0;
                            end else begin
                                FetchValid <= 1'b1;
                                FetchData  <= '0;
                            end
                        end else begin
                            MemReq    <= 1'b1;
                            MemAddr   <= sel_addr;
                            MemWidth  <= sel_width;
                            MemWrite  <= grant_data & DataWrite;
                            MemWrData <= grant_data ? DataWrData : '0;
                            tmo_cnt   <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        MemReq   <= 1'b0;
                        BusError <= timed_out;
                        if (cur_data) begin
                            DataValid  <= 1'b1;
                            DataRdData <= (MemReady && !MemWrite) ? MemRdData : '0;
                        end else begin
                            FetchValid <= 1'b1;
                            FetchData  <= MemReady ? MemRdData : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sol32_mem_arbiter.sv
// Bench for sol32_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant choice, alignment, timeout, results).
// Two DUTs share stimulus: the main one with FAIR=1, a second with FAIR=0.
module tb_sol32_mem_arbiter;

    localparam int TMO = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        FetchReq, DataRead, DataWrite, MemReady;
    logic [31:0] FetchAddr, DataAddr, DataWrData, MemRdData;
    logic [1:0]  DataWidth;

    logic        FetchValid, DataValid, MemReq, MemWrite, BusError, Stall;
    logic [31:0] FetchData, DataRdData, MemAddr, MemWrData;
    logic [1:0]  MemWidth;

    logic        f0_FetchValid, f0_DataValid, f0_MemReq, f0_MemWrite, f0_BusError, f0_Stall;
    logic [31:0] f0_FetchData, f0_DataRdData, f0_MemAddr, f0_MemWrData;
    logic [1:0]  f0_MemWidth;

    int total = 0;
    int bad   = 0;

    // Model state: who won the last memory access, and the held result registers.
    bit          m_last_data;
    logic [31:0] m_fdata, m_ddata;

    always #5 Clock = ~Clock;

    sol32_mem_arbiter #(.TIMEOUT(TMO), .FAIR(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchValid(FetchValid), .FetchData(FetchData),
        .DataRead(DataRead), .DataWrite(DataWrite), .DataWidth(DataWidth), .DataAddr(DataAddr),
        .DataWrData(DataWrData), .DataValid(DataValid), .DataRdData(DataRdData),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemWidth(MemWidth), .MemAddr(MemAddr),
        .MemWrData(MemWrData), .MemReady(MemReady), .MemRdData(MemRdData),
        .BusError(BusError), .Stall(Stall)
    );

    sol32_mem_arbiter #(.TIMEOUT(TMO), .FAIR(0)) dut_f0 (
        .Clock(Clock), .Reset(Reset),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchValid(f0_FetchValid), .FetchData(f0_FetchData),
        .DataRead(DataRead), .DataWrite(DataWrite), .DataWidth(DataWidth), .DataAddr(DataAddr),
        .DataWrData(DataWrData), .DataValid(f0_DataValid), .DataRdData(f0_DataRdData),
        .MemReq(f0_MemReq), .MemWrite(f0_MemWrite), .MemWidth(f0_MemWidth), .MemAddr(f0_MemAddr),
        .MemWrData(f0_MemWrData), .MemReady(MemReady), .MemRdData(MemRdData),
        .BusError(f0_BusError), .Stall(f0_Stall)
    );

    task automatic clear_inputs();
        FetchReq = 0; FetchAddr = 0; DataRead = 0; DataWrite = 0; DataWidth = 0;
        DataAddr = 0; DataWrData = 0; MemReady = 0; MemRdData = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        m_last_data = 1'b1;
        m_fdata = '0;
        m_ddata = '0;
    endtask

    task automatic idle_cycle();
        @(posedge Clock);
        #1;
    endtask

    // Runs one access starting in an IDLE cycle with requests already driven.
    // Acts as memory (MemReady after w wait cycles) and returns positioned in RESP.
    task automatic one_access(input int w, input logic [31:0] rdata);
        logic        freq, dreq, gd, wr, fault, tmo, err, exp_stall;
        logic [1:0]  wid;
        logic [31:0] addr, wdat, res;
        freq = FetchReq;
        dreq = DataRead || DataWrite;
        if (freq && dreq) gd = m_last_data ? 1'b0 : 1'b1;
        else              gd = dreq;
        wid  = gd ? DataWidth : 2'b10;
        addr = gd ? DataAddr : FetchAddr;
        wdat = DataWrData;
        wr   = gd && DataWrite;
        case (wid)
            2'b00:   fault = 1'b0;
            2'b01:   fault = (addr % 2) != 0;
            2'b10:   fault = (addr % 4) != 0;
            default: fault = 1'b1;
        endcase
        tmo = !fault && (w >= TMO);
        err = fault || tmo;
        res = (err || wr) ? 32'h0 : rdata;

        @(posedge Clock);
        #1;
        if (!fault) begin
            for (int k = 0; k < TMO; k++) begin
                total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL access_memreq k=%0d got=%b exp=1", k, MemReq); end
                total++; if (MemAddr !== addr) begin bad++; $display("FAIL access_addr k=%0d got=%h exp=%h", k, MemAddr, addr); end
                total++; if (MemWidth !== wid) begin bad++; $display("FAIL access_width k=%0d got=%b exp=%b", k, MemWidth, wid); end
                total++; if (MemWrite !== wr) begin bad++; $display("FAIL access_write k=%0d got=%b exp=%b", k, MemWrite, wr); end
                if (wr) begin
                    total++; if (MemWrData !== wdat) begin bad++; $display("FAIL access_wrdata k=%0d got=%h exp=%h", k, MemWrData, wdat); end
                end
                total++; if ((FetchValid | DataValid) !== 1'b0) begin bad++; $display("FAIL access_novalid k=%0d got=%b%b exp=00", k, FetchValid, DataValid); end
                total++; if (Stall !== 1'b1) begin bad++; $display("FAIL access_stall k=%0d got=%b exp=1", k, Stall); end
                MemReady  = (k == w);
                MemRdData = (k == w) ? rdata : $urandom;
                if (k == w || k == TMO - 1) break;
                @(posedge Clock);
                #1;
            end
            @(posedge Clock);
            #1;
            MemReady  = 1'b0;
            MemRdData = $urandom;
        end

        if (gd) m_ddata = res;
        else    m_fdata = res;
        if (!fault) m_last_data = gd;
        exp_stall = (freq && gd) || (dreq && !gd);

        total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL resp_memreq got=%b exp=0", MemReq); end
        total++; if (FetchValid !== !gd) begin bad++; $display("FAIL resp_fvalid got=%b exp=%b", FetchValid, !gd); end
        total++; if (DataValid !== gd) begin bad++; $display("FAIL resp_dvalid got=%b exp=%b", DataValid, gd); end
        total++; if (BusError !== err) begin bad++; $display("FAIL resp_buserr got=%b exp=%b", BusError, err); end
        total++; if (FetchData !== m_fdata) begin bad++; $display("FAIL resp_fdata got=%h exp=%h", FetchData, m_fdata); end
        total++; if (DataRdData !== m_ddata) begin bad++; $display("FAIL resp_ddata got=%h exp=%h", DataRdData, m_ddata); end
        total++; if (Stall !== exp_stall) begin bad++; $display("FAIL resp_stall got=%b exp=%b", Stall, exp_stall); end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL rst_memreq got=%b exp=0", MemReq); end
        total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL rst_fvalid got=%b exp=0", FetchValid); end
        total++; if (DataValid !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%b exp=0", DataValid); end
        total++; if (BusError !== 1'b0) begin bad++; $display("FAIL rst_buserr got=%b exp=0", BusError); end
        total++; if (FetchData !== 32'h0) begin bad++; $display("FAIL rst_fdata got=%h exp=0", FetchData); end
        total++; if (DataRdData !== 32'h0) begin bad++; $display("FAIL rst_ddata got=%h exp=0", DataRdData); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", Stall); end
    endtask

    task automatic test_fetch_basic();
        FetchReq  = 1'b1;
        FetchAddr = 32'h100;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_idle got=%b exp=1", Stall); end
        one_access(0, 32'hDEADBEEF);
        total++; if (FetchData !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_data got=%h exp=deadbeef", FetchData); end
        total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b exp=1", FetchValid); end
        FetchReq = 1'b0;
        idle_cycle();
        total++; if (FetchValid !== 1'b0) begin bad++; $display("FAIL fetch_valid_one_cycle got=%b exp=0", FetchValid); end
    endtask

    task automatic test_store();
        DataWrite  = 1'b1;
        DataWidth  = 2'b10;
        DataAddr   = 32'h204;
        DataWrData = 32'h12345678;
        one_access(4, 32'hCAFEF00D);
        total++; if (BusError !== 1'b0) begin bad++; $display("FAIL store_buserr got=%b exp=0", BusError); end
        total++; if (DataRdData !== 32'h0) begin bad++; $display("FAIL store_rddata got=%h exp=0", DataRdData); end
        DataWrite = 1'b0;
        idle_cycle();
    endtask

    task automatic test_misaligned();
        logic [1:0]  widths [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs  [3] = '{32'h202, 32'h301, 32'h400};
        for (int i = 0; i < 3; i++) begin
            DataRead  = 1'b1;
            DataWidth = widths[i];
            DataAddr  = addrs[i];
            one_access(0, 32'h55AA55AA);
            total++; if ((DataValid & BusError) !== 1'b1) begin bad++; $display("FAIL misalign_strobes i=%0d got=%b%b exp=11", i, DataValid, BusError); end
            DataRead = 1'b0;
            idle_cycle();
        end
    endtask

    task automatic test_timeout();
        FetchReq  = 1'b1;
        FetchAddr = 32'h300;
        one_access(100, 32'h11111111);
        total++; if ((FetchValid & BusError) !== 1'b1) begin bad++; $display("FAIL tmo_strobes got=%b%b exp=11", FetchValid, BusError); end
        total++; if (FetchData !== 32'h0) begin bad++; $display("FAIL tmo_fdata got=%h exp=0", FetchData); end
        FetchReq = 1'b0;
        idle_cycle();
        FetchReq = 1'b1;
        one_access(TMO - 1, 32'h22222222);
        total++; if (BusError !== 1'b0) begin bad++; $display("FAIL tmo_lastcycle_err got=%b exp=0", BusError); end
        total++; if (FetchData !== 32'h22222222) begin bad++; $display("FAIL tmo_lastcycle_data got=%h exp=22222222", FetchData); end
        FetchReq = 1'b0;
        idle_cycle();
    endtask

    task automatic test_arbitration();
        logic exp_fetch;
        apply_reset();
        FetchReq  = 1'b1;
        FetchAddr = 32'h40;
        DataRead  = 1'b1;
        DataWidth = 2'b10;
        DataAddr  = 32'h80;
        for (int i = 0; i < 6; i++) begin
            one_access(0, $urandom);
            exp_fetch = (i % 2) == 0;
            total++; if (FetchValid !== exp_fetch) begin bad++; $display("FAIL rr_alternate i=%0d got=%b exp=%b", i, FetchValid, exp_fetch); end
            total++; if (f0_DataValid !== 1'b1 || f0_FetchValid !== 1'b0) begin bad++; $display("FAIL fixed_prio i=%0d got=%b%b exp=01", i, f0_FetchValid, f0_DataValid); end
            idle_cycle();
        end
        clear_inputs();
        repeat (3) idle_cycle();
    endtask

    task automatic test_reset_mid_access();
        FetchReq  = 1'b1;
        FetchAddr = 32'h500;
        idle_cycle();
        total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", MemReq); end
        #2;
        Reset = 1'b0;
        #1;
        total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL midrst_memreq got=%b exp=0", MemReq); end
        total++; if ((FetchValid | DataValid | BusError) !== 1'b0) begin bad++; $display("FAIL midrst_strobes got=%b%b%b exp=000", FetchValid, DataValid, BusError); end
        clear_inputs();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        m_last_data = 1'b1;
        m_fdata = '0;
        m_ddata = '0;
        FetchReq  = 1'b1;
        FetchAddr = 32'h600;
        DataRead  = 1'b1;
        DataWidth = 2'b10;
        DataAddr  = 32'h700;
        one_access(0, 32'h0BADF00D);
        total++; if (FetchValid !== 1'b1) begin bad++; $display("FAIL midrst_first_tie got=%b exp=1", FetchValid); end
        clear_inputs();
        idle_cycle();
    endtask

    task automatic test_random();
        logic [31:0] r, a;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            FetchReq  = r[0];
            DataRead  = r[1];
            DataWrite = r[2];
            if (!r[0] && !r[1] && !r[2]) FetchReq = 1'b1;
            DataWidth = 2'($urandom_range(0, 3));
            a = $urandom;
            FetchAddr = (r[5:4] == 2'b00) ? a : {a[31:2], 2'b00};
            a = $urandom;
            DataAddr  = (r[7:6] == 2'b00) ? a : {a[31:2], 2'b00};
            DataWrData = $urandom;
            one_access($urandom_range(0, 9), $urandom);
            clear_inputs();
            idle_cycle();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_basic();
        test_store();
        test_misaligned();
        test_timeout();
        test_arbitration();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sol32_mem_arbiter.md
Name: sol32_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the sol32 core's instruction-fetch port and its load/store port.
- Sequences each access as a request/ready handshake toward memory and returns one-cycle result strobes to the core.
- Produces a Stall signal that freezes the core while either of its requests is outstanding.
- Sits between the core and the memory/interconnect; contains a round-robin arbiter, an access FSM and a bus-timeout watchdog.

Parameters:
- TIMEOUT, 255: cycles MemReq may remain unanswered before the access is aborted; legal range 1..65535.
- FAIR, 1: 1 selects round-robin between fetch and data; 0 selects fixed data-over-fetch priority.

Ports:
- Clock in 1: sole clock, rising edge.
- Reset in 1: asynchronous, active-low reset.
- FetchReq in 1: instruction fetch request, held until FetchValid.
- FetchAddr in 32: fetch address.
- FetchValid out 1: one-cycle strobe, FetchData valid.
- FetchData out 32: fetched instruction word.
- DataRead in 1: load request, held until DataValid.
- DataWrite in 1: store request, held until DataValid.
- DataWidth in 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
- DataAddr in 32: load/store address.
- DataWrData in 32: store data.
- DataValid out 1: one-cycle strobe, load/store complete.
- DataRdData out 32: load result.
- MemReq out 1: memory request.
- MemWrite out 1: 1 means store.
- MemWidth out 2: size forwarded to memory.
- MemAddr out 32: memory address.
- MemWrData out 32: memory write data.
- MemReady in 1: memory accepted/completed the access this cycle.
- MemRdData in 32: read data, valid with MemReady.
- BusError out 1: one-cycle strobe on a timeout or alignment fault.
- Stall out 1: core must hold state.

Behaviour:
- Reset (Reset low, asynchronous):
  - State=IDLE; LastGrant=data, so fetch wins the first tie.
  - All registered outputs are 0, including MemReq, FetchValid, DataValid, BusError, FetchData, DataRdData and timeout counter.
  - Reset mid-access drops MemReq immediately; memory side must tolerate an abandoned access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample FetchReq and DataReq (DataReq = DataRead|DataWrite).
  - If DataRead and DataWrite are both 1: treat as a write.
  - Neither pending: stay in IDLE.
  - Exactly one pending: grant it.
  - Both pending, FAIR=1: grant the one not equal to LastGrant.
  - Both pending, FAIR=0: grant data.
- Alignment check on a data grant (no memory access is issued on a fault):
  - Fault when DataWidth=11, DataWidth=01 with DataAddr[0]=1, or DataWidth=10 with DataAddr[1:0]!=00.
  - On fault go directly to RESP with error: DataRdData=0, BusError=1.
- Fetch grants:
  - Always width 10.
  - FetchAddr[1:0]!=00 is an alignment fault handled the same way: FetchData=0, BusError=1.
- Entering ACCESS (next edge after grant):
  - Register MemAddr, MemWrite, MemWidth, MemWrData from the granted requester.
  - Assert MemReq; these registered values stay stable while MemReq=1.
  - Set LastGrant and clear the timeout counter.
- ACCESS:
  - MemReady=1: capture MemRdData into FetchData or DataRdData; stores capture 0 into DataRdData. Drop MemReq, go to RESP.
  - Otherwise the counter increments.
  - Counter reaches TIMEOUT-1 with no MemReady: drop MemReq, result=0, go to RESP with error.
  - MemReady in the same cycle as the timeout wins; no error is flagged.
- RESP (exactly one cycle):
  - Pulse FetchValid or DataValid per grant; pulse BusError if flagged.
  - Then return to IDLE.
- Latency: a zero-wait memory (MemReady in the first ACCESS cycle) completes as grant→ACCESS→RESP, i.e. Valid 3 cycles after the request is seen in IDLE.
- Requester rules:
  - A request still high in the cycle after Valid is a new access.
  - Request inputs that change while not granted are sampled only in IDLE.
- Stall = (FetchReq & ~FetchValid) | (DataReq & ~DataValid), combinational; it is 0 in the Valid cycle.
- Data and fetch result registers hold their value until the next capture.

Decomposition:
- Package sol32_bus_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, RESP}.
  - typedef enum width_t {W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10, W_RSVD=2'b11}.
  - Function is_misaligned(width, addr[1:0]).
- Sub-module sol32_rr_arbiter:
  - Two-requester round-robin with FAIR parameter and LastGrant flop.
  - Combinational grant, registered state updated on an accept strobe from the FSM.

Test Plan:
- Fetch only, FetchAddr=0x100, MemReady on 1st ACCESS cycle, MemRdData=0xDEADBEEF → MemReq=1 for 1 cycle with MemAddr=0x100, MemWidth=10; FetchValid pulse with FetchData=0xDEADBEEF 3 cycles after request; Stall high until then.
- FetchReq and DataRead both held, FAIR=1, zero-wait memory → grants alternate fetch, data, fetch, …; with FAIR=0 data is always granted first.
- Store DataAddr=0x204, DataWidth=10, DataWrData=0x12345678, MemReady after 4 wait cycles → MemWrite=1 and MemAddr/MemWrData stable for 5 cycles; DataValid pulse; BusError=0.
- Load DataWidth=10, DataAddr=0x202 → no MemReq; DataValid and BusError pulse together; DataRdData=0.
- TIMEOUT=8, fetch with MemReady never asserted → MemReq high exactly 8 cycles then drops; FetchValid+BusError pulse; FetchData=0. MemReady arriving on cycle 8 instead → no error.
- Reset low during ACCESS with MemReq=1 → MemReq, Stall-driving outputs and Valids go 0 asynchronously; after release the first tie goes to fetch.
